// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared HI/LO encodings and timing constants used by the decoder, the
//   ID/EX register and the multiply/divide unit, plus the result helpers
//   that produce a full {HI,LO} pair from two 32-bit operands.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    HILO_NONE  = 3'd0,
    HILO_MULT  = 3'd1,
    HILO_MULTU = 3'd2,
    HILO_DIV   = 3'd3,
    HILO_DIVU  = 3'd4
  } hilo_op_e;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_MTHI = 2'd1,
    HW_MTLO = 2'd2
  } hilo_wr_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // Pending result: wr=0 means commit leaves HI/LO untouched (divide by 0).
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } hilo_res_t;

  function automatic hilo_res_t mul_res(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    hilo_res_t   r;
    ea   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    p    = ea * eb;
    r.hi = p[63:32];
    r.lo = p[31:0];
    r.wr = 1'b1;
    return r;
  endfunction

  // Signed divide is done on magnitudes and re-signed afterwards, so the
  // 0x80000000 / -1 overflow case falls out as 0x80000000 rem 0 without
  // relying on the behaviour of a signed overflowing '/'.
  function automatic hilo_res_t div_res(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] rm;
    logic        neg_q;
    logic        neg_r;
    hilo_res_t   r;
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    ua    = (sgn && a[31]) ? (32'd0 - a) : a;
    ub    = (sgn && b[31]) ? (32'd0 - b) : b;
    r     = '0;
    if (ub != '0) begin
      q    = ua / ub;
      rm   = ua % ub;
      r.lo = neg_q ? (32'd0 - q) : q;
      r.hi = neg_r ? (32'd0 - rm) : rm;
      r.wr = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   The result is computed at acceptance and held as pending until the
//   cycle counter expires, so HI/LO only change at completion.
// Ports
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   hiloOpE     op select (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU)
//   hiloWriteE  0 none, 1 MTHI, 2 MTLO
//   srcAE       rs operand / MTxx data
//   srcBE       rt operand
//   hiloSelE    read select: 0 HI, 1 LO
//   start       combinational decode of a valid op
//   busy        operation in flight
//   hiloRdE     committed HI or LO
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  hiloOpE,
  input  logic [1:0]  hiloWriteE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        hiloSelE,
  output logic        start,
  output logic        busy,
  output logic [31:0] hiloRdE
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  hilo_res_t   pend_q;
  hilo_res_t   res_d;
  logic        is_div;

  always_comb begin
    res_d  = '0;
    is_div = 1'b0;
    case (hiloOpE)
      HILO_MULT:  res_d = mul_res(srcAE, srcBE, 1'b1);
      HILO_MULTU: res_d = mul_res(srcAE, srcBE, 1'b0);
      HILO_DIV: begin
        res_d  = div_res(srcAE, srcBE, 1'b1);
        is_div = 1'b1;
      end
      HILO_DIVU: begin
        res_d  = div_res(srcAE, srcBE, 1'b0);
        is_div = 1'b1;
      end
      default: ;
    endcase
  end

  assign start   = (hiloOpE == HILO_MULT) || (hiloOpE == HILO_MULTU) ||
                   (hiloOpE == HILO_DIV)  || (hiloOpE == HILO_DIVU);
  assign busy    = (state_q == ST_BUSY);
  assign hiloRdE = hiloSelE ? lo_q : hi_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            if (pend_q.wr) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
          end
        end
        default: begin
          // An accepted op takes priority over a same-edge MTHI/MTLO.
          if (start) begin
            state_q <= ST_BUSY;
            cnt_q   <= is_div ? DIV_CYCLES : MULT_CYCLES;
            pend_q  <= res_d;
          end else if (hiloWriteE == HW_MTHI) begin
            hi_q <= srcAE;
          end else if (hiloWriteE == HW_MTLO) begin
            lo_q <= srcAE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  hiloOpE;
  logic [1:0]  hiloWriteE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        hiloSelE;
  logic        start;
  logic        busy;
  logic [31:0] hiloRdE;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pw;
  int          m_rem;

  mult_div_unit dut (
    .clk(clk), .resetn(resetn), .hiloOpE(hiloOpE), .hiloWriteE(hiloWriteE),
    .srcAE(srcAE), .srcBE(srcBE), .hiloSelE(hiloSelE),
    .start(start), .busy(busy), .hiloRdE(hiloRdE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: one call per rising edge with the inputs of that edge.
  task automatic model_step(input logic [2:0] op, input logic [1:0] wr,
                            input logic [31:0] a, input logic [31:0] b, input logic rn);
    longint sa, sb, q, r, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    if (!rn) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pw = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pw) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (op >= 3'd1 && op <= 3'd4) begin
      m_pw = 1;
      case (op)
        3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_rem = 5; end
        3'd2: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; m_rem = 5; end
        3'd3: begin
          m_rem = 10;
          if (b == 0) m_pw = 0;
          else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        default: begin
          m_rem = 10;
          if (b == 0) m_pw = 0;
          else begin m_plo = 32'(ua / ub); m_phi = 32'(ua % ub); end
        end
      endcase
    end else if (wr == 2'd1) m_hi = a;
    else if (wr == 2'd2) m_lo = a;
  endtask

  // One clock: drive, check start, advance model, then compare after the edge.
  task automatic cyc(input logic [2:0] op, input logic [1:0] wr,
                     input logic [31:0] a, input logic [31:0] b, input logic rn);
    hiloOpE = op; hiloWriteE = wr; srcAE = a; srcBE = b; resetn = rn;
    hiloSelE = 1'($urandom_range(0, 1));
    #1;
    check("start", {31'b0, start}, {31'b0, (op >= 3'd1 && op <= 3'd4)});
    model_step(op, wr, a, b, rn);
    @(posedge clk);
    #1;
    check("busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
    check("hiloRdE", hiloRdE, hiloSelE ? m_lo : m_hi);
    hiloSelE = ~hiloSelE;
    #1;
    check("hiloRdE_alt", hiloRdE, hiloSelE ? m_lo : m_hi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd0, 2'd0, $urandom, $urandom, 1'b1);
  endtask

  task automatic lit(input string name, input logic sel, input logic [31:0] exp);
    hiloSelE = sel;
    #1;
    check(name, hiloRdE, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pw = 0; m_rem = 0;
    cyc(3'd1, 2'd1, 32'h5, 32'h7, 1'b0);
    cyc(3'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    lit("reset_hi", 1'b0, 32'h0);
    lit("reset_lo", 1'b1, 32'h0);

    // MULT -2 * 3
    cyc(3'd1, 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(4);
    check("mult_busy_5th", {31'b0, busy}, 32'd1);
    idle(1);
    check("mult_busy_done", {31'b0, busy}, 32'd0);
    lit("mult_hi", 1'b0, 32'hFFFF_FFFF);
    lit("mult_lo", 1'b1, 32'hFFFF_FFFA);

    cyc(3'd2, 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(5);
    lit("multu_hi", 1'b0, 32'h0000_0002);
    lit("multu_lo", 1'b1, 32'hFFFF_FFFA);

    // DIV -7 / 2
    cyc(3'd3, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(9);
    check("div_busy_10th", {31'b0, busy}, 32'd1);
    idle(1);
    lit("div_lo", 1'b1, 32'hFFFF_FFFD);
    lit("div_hi", 1'b0, 32'hFFFF_FFFF);

    cyc(3'd4, 2'd0, 32'd7, 32'd2, 1'b1);
    idle(10);
    lit("divu_lo", 1'b1, 32'd3);
    lit("divu_hi", 1'b0, 32'd1);

    cyc(3'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle(10);
    lit("divovf_lo", 1'b1, 32'h8000_0000);
    lit("divovf_hi", 1'b0, 32'h0);

    // MTHI / MTLO
    cyc(3'd0, 2'd1, 32'h1234_5678, 32'd0, 1'b1);
    cyc(3'd0, 2'd2, 32'h9ABC_DEF0, 32'd0, 1'b1);
    lit("mthi", 1'b0, 32'h1234_5678);
    lit("mtlo", 1'b1, 32'h9ABC_DEF0);

    // Op + MTxx on same idle edge: op wins
    cyc(3'd2, 2'd2, 32'd6, 32'd7, 1'b1);
    idle(5);
    lit("op_over_mt_lo", 1'b1, 32'd42);

    // Ops and MTLO while busy are ignored
    cyc(3'd1, 2'd0, 32'd3, 32'd5, 1'b1);
    idle(1);
    cyc(3'd1, 2'd2, 32'h0000_AAAA, 32'd7, 1'b1);
    idle(2);
    check("hazard_busy", {31'b0, busy}, 32'd1);
    idle(1);
    check("hazard_not_ext", {31'b0, busy}, 32'd0);
    lit("hazard_hi", 1'b0, 32'd0);
    lit("hazard_lo", 1'b1, 32'd15);

    // Reset mid-DIV aborts it
    cyc(3'd3, 2'd0, 32'd100, 32'd3, 1'b1);
    idle(3);
    cyc(3'd0, 2'd0, 32'd0, 32'd0, 1'b0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    idle(11);
    lit("abort_hi", 1'b0, 32'd0);
    lit("abort_lo", 1'b1, 32'd0);

    // Divide by zero leaves HI/LO alone
    cyc(3'd0, 2'd1, 32'h11, 32'd0, 1'b1);
    cyc(3'd0, 2'd2, 32'h22, 32'd0, 1'b1);
    cyc(3'd3, 2'd0, 32'd5, 32'd0, 1'b1);
    idle(9);
    check("div0_busy", {31'b0, busy}, 32'd1);
    idle(1);
    lit("div0_hi", 1'b0, 32'h11);
    lit("div0_lo", 1'b1, 32'h22);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] op;
      logic [1:0] wr;
      op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      if (busy && $urandom_range(0, 1) == 0) op = 3'd0;
      wr = 2'($urandom_range(0, 3));
      cyc(op, wr, pick(), pick(), ($urandom_range(0, 60) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: resetn  input  1  synchronous, active-low reset.
REQ-003 SHALL provide: hiloOpE  input  3  op from ID/EX register: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5-7 none.
REQ-004 SHALL provide: hiloWriteE  input  2  0 none, 1 MTHI, 2 MTLO, 3 none.
REQ-005 SHALL provide: srcAE  input  32  forwarded rs operand (dividend / multiplicand / MTxx data).
REQ-006 SHALL provide: srcBE  input  32  forwarded rt operand (divisor / multiplier).
REQ-007 SHALL provide: hiloSelE  input  1  read select: 0 HI, 1 LO.
REQ-008 SHALL provide: start  output  1  combinational; 1 when hiloOpE is 1-4.
REQ-009 SHALL provide: busy  output  1  registered; 1 while an operation is in flight.
REQ-010 SHALL provide: hiloRdE  output  32  combinational read of HI or LO per hiloSelE (for MFHI/MFLO).

Function
REQ-011 SHALL accept an op on an edge where hiloOpE is 1-4, resetn=1 and busy=0; accepted op loads counter with MULT_CYCLES=5 (ops 1,2) or DIV_CYCLES=10 (ops 3,4) and sets busy=1.
REQ-012 SHALL latch the full result (pendHi, pendLo) at acceptance from srcAE/srcBE on that edge; later operand changes have no effect.
REQ-013 SHALL decrement counter each edge while busy; on the edge where counter==1, HI<=pendHi, LO<=pendLo, counter<=0, busy<=0.
REQ-014 Latency: busy high exactly N cycles after acceptance edge; new HI/LO visible on hiloRdE in the first cycle busy=0.
REQ-015 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-016 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-017 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 Divisor 0 (DIV or DIVU): op SHALL still run full 10 cycles with busy; HI and LO left unchanged at completion.
REQ-019 hiloOpE 1-4 arriving while busy=1 SHALL be ignored (hazard unit guarantees stall; no queuing).
REQ-020 MTHI/MTLO with busy=0 SHALL write srcAE into HI/LO on that edge; ignored while busy=1.
REQ-021 hiloOpE 1-4 and hiloWriteE!=0 on same edge with busy=0: op accepted, MTxx ignored.
REQ-022 hiloRdE SHALL reflect committed HI/LO only (never pending values), including while busy.
REQ-023 start SHALL be independent of busy (pure decode), for hazard-unit stall use (stall = (start|busy) & md-class instr in ID).

Reset
REQ-024 resetn=0 on an edge SHALL set HI=0, LO=0, busy=0, counter=0, pendHi=pendLo=0, overriding any op or MTxx on that edge.
REQ-025 Reset mid-operation SHALL abort it; no commit of pending result afterwards.
REQ-026 After reset, hiloRdE=0 for both selects; start follows hiloOpE combinationally regardless of reset.

Structure
REQ-027 Shared package SHALL hold op encodings (HILO_NONE, HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU), write encodings (HW_NONE, HW_MTHI, HW_MTLO) and constants MULT_CYCLES=5, DIV_CYCLES=10; the same package is used by the decoder and ID/EX register.
REQ-028 Counter width SHALL be 4 bits; arithmetic uses behavioural * / % on sign-handled 32-bit operands, no sub-module required.
REQ-029 Single always block for sequential state; combinational outputs separate.

Verification
REQ-030 MULT srcA=0xFFFFFFFE (-2), srcB=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-032 MTHI 0x12345678 then MTLO 0x9ABCDEF0 (busy=0) -> hiloRdE=0x12345678 (sel 0), 0x9ABCDEF0 (sel 1) next cycle.
REQ-033 Start MULT, issue MTLO 0xAAAA and second MULT at cycle 2 -> both ignored; HI/LO = first product at cycle 5; busy not extended.
REQ-034 Start DIV, assert resetn=0 at cycle 4 -> busy=0, HI=LO=0 next cycle, remain 0 through cycle 15.
REQ-035 DIV x/0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
